wrap_input: RTL and testbench
=============================

// Module: wrap_input
// PURPOSE
// - Elastic buffer between a valid/ready producer and a valid/ready consumer: a 7-entry, 32-bit, in-order,
//   lossless FIFO. Data is accepted on the io_c side and delivered on the io_p side.
// - Sits between a sequence generator and a sequence checker. Decouples bursty upstream traffic from
//   stalling downstream traffic.
// PARAMETERS
// - WIDTH  32  data width in bits.
// - DEPTH  7   number of storage entries; need not be a power of two.
// - USZ    $clog2(DEPTH+1)=3  width of the occupancy count (derived; do not override).
// PORTS
// - clk         in   1      single clock; all logic on posedge.
// - reset       in   1      synchronous reset, active-high.
// - io_c_valid  in   1      upstream data valid.
// - io_c_ready  out  1      buffer can accept a word this cycle.
// - io_c_bits   in   WIDTH  upstream data.
// - io_p_valid  out  1      buffer holds a word for downstream.
// - io_p_ready  in   1      downstream accepts the word this cycle.
// - io_p_bits   out  WIDTH  head-of-FIFO data.
// BEHAVIOUR
// - Push: io_c_valid & io_c_ready at posedge writes io_c_bits at wr_ptr. wr_ptr then advances.
// - Pop: io_p_valid & io_p_ready at posedge retires the head entry. rd_ptr then advances.
// - Pointer wrap: each pointer runs 0..DEPTH-1, then returns to 0 (explicit compare, not modulo-2^n).
// - count[USZ-1:0] range 0..DEPTH:
//   - push only: count+1; pop only: count-1; push and pop together: unchanged.
// - io_c_ready = (count != DEPTH). io_p_valid = (count != 0). io_p_bits = mem[rd_ptr].
// - All three outputs are driven by registers or by state-only decode. There is no comb path from
//   io_c_valid or io_p_ready to any output.
// - Latency: a word pushed into an empty FIFO gives io_p_valid=1 on the next cycle. No bypass.
// - Full (count=7): io_c_ready=0, so io_c_valid is ignored. A pop in that cycle frees a slot;
//   io_c_ready=1 on the next cycle.
// - Empty (count=0): io_p_valid=0, so io_p_ready is ignored. io_p_bits is don't-care.
// - Simultaneous push and pop at count 1..6: both happen; order is preserved.
// - Data words are never dropped, duplicated or reordered.
// - Reset (also mid-operation): the next cycle has wr_ptr=rd_ptr=count=0, io_p_valid=0, io_c_ready=1.
//   All stored contents are discarded. Storage array is not reset.
// CONFIGURATION
// - USAGE_OUT_EN defined: add output port io_usage [USZ-1:0] = count (registered). It reads 0 after reset
//   and 7 when full.
// - USAGE_OUT_EN undefined: no io_usage port. Core behaviour is identical.
// STRUCTURE
// - Package wrap_input_pkg holds:
//   - WIDTH and DEPTH defaults;
//   - USZ;
//   - typedef data_t = logic [WIDTH-1:0];
//   - typedef cnt_t = logic [USZ-1:0];
//   - a pointer-increment-with-wrap function.
// - One sub-module, wrap_input_ctrl: pointers, count, ready/valid generation, write enable.
// - The top holds the DEPTH x WIDTH register array and the read mux.
// TESTING
// - Bench: incrementing-sequence generator -> DUT -> sequence checker. Checker counts in-order words;
//   any mismatch fails.
// - T1 reset: reset=1 for 5 cycles -> io_c_ready=1, io_p_valid=0. With USAGE_OUT_EN, io_usage=0.
// - T2 streaming: generator always valid, checker always ready, 20 cycles -> one word per cycle after
//   1 cycle of latency. Values are 0,1,2,... in order.
// - T3 overflow: source pattern 0xFD, sink pattern 0x03 -> count saturates at 7 and io_c_ready drops.
//   No loss: the checker sees a contiguous sequence.
// - T4 underflow: source 0x11, sink 0xEE -> FIFO drains to 0 and io_p_valid=0 while empty.
//   No spurious words are delivered.
// - T5 wrap and simultaneous events: random 8-bit valid/ready patterns, changed every 16 cycles, for 1000
//   words -> pointers wrap many times. Checker ok count >= 1000 within 10000 cycles.
// - T6 mid-op reset: reset asserted at count=4 -> count=0 next cycle. Old data is never delivered.

Source files
------------

// File: rtl/wrap_input_pkg.sv
// Shared types and constants for the wrap_input elastic buffer.
// Build option: define USAGE_OUT_EN to expose the occupancy count as io_usage.
package wrap_input_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 7;
    // Occupancy must represent 0..DEPTH inclusive.
    localparam int unsigned USZ   = $clog2(DEPTH + 1);
    localparam int unsigned PSZ   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [USZ-1:0]   cnt_t;
    typedef logic [PSZ-1:0]   ptr_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

    // Advance a storage pointer, wrapping explicitly after the last entry
    // so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/wrap_input_ctrl.sv
// Pointer, occupancy and handshake control for the wrap_input FIFO.
// Build option: USAGE_OUT_EN adds the usage output (the registered count).
module wrap_input_ctrl
    import wrap_input_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic c_valid,
    input  logic p_ready,
    output logic c_ready,
    output logic p_valid,
    output logic we,
    output ptr_t wr_ptr,
    output ptr_t rd_ptr
`ifdef USAGE_OUT_EN
    ,
    output cnt_t usage
`endif
);

    cnt_t count;
    logic push;
    logic pop;

    // Handshake flags decode from state only; no path from c_valid/p_ready to outputs.
    always_comb begin
        c_ready = (count != CNT_FULL);
        p_valid = (count != '0);
        push    = c_valid & c_ready;
        pop     = p_valid & p_ready;
        we      = push;
    end

    // Pointer and occupancy update; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef USAGE_OUT_EN
    // Count is itself a register, so usage is registered.
    assign usage = count;
`endif

endmodule

// File: rtl/wrap_input.sv
// wrap_input: 7-entry, 32-bit in-order valid/ready FIFO (io_c in, io_p out).
// Build option: USAGE_OUT_EN adds io_usage reporting the current occupancy.
module wrap_input
    import wrap_input_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             io_c_valid,
    output logic             io_c_ready,
    input  logic [WIDTH-1:0] io_c_bits,
    output logic             io_p_valid,
    input  logic             io_p_ready,
    output logic [WIDTH-1:0] io_p_bits
`ifdef USAGE_OUT_EN
    ,
    output logic [USZ-1:0]   io_usage
`endif
);

    data_t mem [DEPTH];
    logic  we;
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;

    wrap_input_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .c_valid (io_c_valid),
        .p_ready (io_p_ready),
        .c_ready (io_c_ready),
        .p_valid (io_p_valid),
        .we      (we),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
`ifdef USAGE_OUT_EN
        ,
        .usage   (io_usage)
`endif
    );

    // Storage is deliberately not reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= io_c_bits;
        end
    end

    // Head of FIFO; don't-care while empty.
    assign io_p_bits = mem[rd_ptr];

endmodule

// File: tb/tb_wrap_input.sv
// Bench for wrap_input: incrementing generator -> DUT -> sequence checker,
// with a queue-based reference model of the FIFO contents.
module tb_wrap_input;

    localparam int DEPTH = 7;

    logic        clk;
    logic        reset;
    logic        io_c_valid;
    logic        io_c_ready;
    logic [31:0] io_c_bits;
    logic        io_p_valid;
    logic        io_p_ready;
    logic [31:0] io_p_bits;
`ifdef USAGE_OUT_EN
    logic [2:0]  io_usage;
`endif

    wrap_input dut (
        .clk        (clk),
        .reset      (reset),
        .io_c_valid (io_c_valid),
        .io_c_ready (io_c_ready),
        .io_c_bits  (io_c_bits),
        .io_p_valid (io_p_valid),
        .io_p_ready (io_p_ready),
        .io_p_bits  (io_p_bits)
`ifdef USAGE_OUT_EN
        ,
        .io_usage   (io_usage)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic [31:0] gen_val = 0;
    logic [31:0] exp_seq = 0;
    int          ok_count = 0;
    int          pops = 0;
    int          cyc = 0;
    bit          chk_en = 0;
    bit          saw_full = 0;
    bit          saw_empty = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input logic [7:0] src, input logic [7:0] snk, input bit rst);
        bit push;
        bit pop;
        @(negedge clk);
        if (chk_en) begin
            check_eq("c_ready", io_c_ready, (q.size() != DEPTH));
            check_eq("p_valid", io_p_valid, (q.size() != 0));
            if (q.size() != 0) check_eq("head", io_p_bits, q[0]);
`ifdef USAGE_OUT_EN
            check_eq("usage", io_usage, q.size());
`endif
        end
        if (!io_c_ready) saw_full = 1;
        if (!io_p_valid) saw_empty = 1;
        reset      = rst;
        io_c_bits  = gen_val;
        io_c_valid = rst ? 1'b0 : src[cyc % 8];
        io_p_ready = rst ? 1'b0 : snk[cyc % 8];
        cyc++;
        if (rst) begin
            q.delete();
            exp_seq = gen_val;
            return;
        end
        push = io_c_valid && (q.size() < DEPTH);
        pop  = io_p_ready && (q.size() > 0);
        if (pop) begin
            if (chk_en) check_eq("pop_seq", io_p_bits, exp_seq);
            exp_seq++;
            ok_count++;
            pops++;
            void'(q.pop_front());
        end
        if (push) begin
            q.push_back(gen_val);
            gen_val++;
        end
    endtask

    initial begin
        logic [7:0] sp;
        logic [7:0] kp;
        int n;
        reset = 1'b1;
        io_c_valid = 1'b0;
        io_p_ready = 1'b0;
        io_c_bits = '0;

        // T1 reset
        step(8'h00, 8'h00, 1);
        chk_en = 1;
        repeat (4) step(8'h00, 8'h00, 1);
        @(posedge clk);
        #1;
        check_eq("t1_c_ready", io_c_ready, 1);
        check_eq("t1_p_valid", io_p_valid, 0);
`ifdef USAGE_OUT_EN
        check_eq("t1_usage", io_usage, 0);
`endif

        // T2 streaming
        pops = 0;
        repeat (20) step(8'hFF, 8'hFF, 0);
        check_eq("t2_pops", pops, 19);
        check_eq("t2_last", exp_seq, 19);

        // T3 overflow
        saw_full = 0;
        repeat (80) step(8'hFD, 8'h03, 0);
        check_eq("t3_saw_full", saw_full, 1);

        // T4 underflow
        saw_empty = 0;
        repeat (80) step(8'h11, 8'hEE, 0);
        check_eq("t4_saw_empty", saw_empty, 1);

        // T5 random patterns, wrap and simultaneous push/pop
        ok_count = 0;
        n = 0;
        sp = 8'hFF;
        kp = 8'hFF;
        while (ok_count < 1000 && n < 10000) begin
            if (n % 16 == 0) begin
                sp = 8'($urandom_range(1, 255));
                kp = 8'($urandom_range(1, 255));
            end
            step(sp, kp, 0);
            n++;
        end
        check_eq("t5_ok_ge_1000", (ok_count >= 1000), 1);

        // T6 mid-operation reset at count 4
        repeat (10) step(8'h00, 8'hFF, 0);
        n = 0;
        while (q.size() != 4 && n < 50) begin
            step(8'hFF, 8'h00, 0);
            n++;
        end
        check_eq("t6_reached4", q.size(), 4);
        step(8'h00, 8'h00, 1);
        @(posedge clk);
        #1;
        check_eq("t6_c_ready", io_c_ready, 1);
        check_eq("t6_p_valid", io_p_valid, 0);
`ifdef USAGE_OUT_EN
        check_eq("t6_usage", io_usage, 0);
`endif
        pops = 0;
        repeat (12) step(8'hFF, 8'hFF, 0);
        check_eq("t6_pops", pops, 11);
        repeat (3) step(8'h00, 8'hFF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
